// File: rtl/chimera_pkg.sv
// Shared types, register offsets and defaults for the cluster sequencing controller.
// Also holds the per-state output encoding used by every cluster sequencer.
package chimera_pkg;

    localparam int unsigned ExtClusters = 5;
    localparam logic [63:0] SnitchBootROMRegionStart = 64'h0000_0000_3000_0000;
    localparam logic [7:0]  DelayDefault = 8'd16;

    localparam logic [11:0] CtrlOffset     = 12'h000;
    localparam logic [11:0] BootAddrOffset = 12'h080;
    localparam logic [11:0] StatusOffset   = 12'h100;
    localparam logic [11:0] DelayOffset    = 12'h180;

    typedef enum logic [2:0] {
        CLUSTER_OFF      = 3'd0,
        CLUSTER_CLK_ON   = 3'd1,
        CLUSTER_RUN      = 3'd2,
        CLUSTER_ISOLATE  = 3'd3,
        CLUSTER_RST_WAIT = 3'd4
    } cluster_seq_state_e;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    // Returns {clk_en, rst, iso} for a sequencer state.
    function automatic logic [2:0] seq_outputs(cluster_seq_state_e s);
        case (s)
            CLUSTER_OFF:      seq_outputs = 3'b011;
            CLUSTER_CLK_ON:   seq_outputs = 3'b111;
            CLUSTER_RUN:      seq_outputs = 3'b100;
            CLUSTER_ISOLATE:  seq_outputs = 3'b101;
            CLUSTER_RST_WAIT: seq_outputs = 3'b111;
            default:          seq_outputs = 3'b011;
        endcase
    endfunction

endpackage

// File: rtl/chimera_cluster_seq.sv
// Power sequencer for one cluster: clock enable, reset and isolation with a delay counter.
//   state    | meaning
//   OFF      | clock gated, reset and isolation asserted
//   CLK_ON   | clock running, reset held for max(DELAY,1) cycles
//   RUN      | cluster running, isolation released
//   ISOLATE  | isolation requested, waiting for iso_ack
//   RST_WAIT | reset asserted, clock kept on for max(DELAY,1) cycles
module chimera_cluster_seq
    import chimera_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] delay_i,
    input  logic       iso_ack_i,
    output logic       clk_en_o,
    output logic       rst_o,
    output logic       iso_o,
    output logic [2:0] state_o
);

    cluster_seq_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] load_val;

    assign load_val = (delay_i == 8'd0) ? 8'd1 : delay_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLUSTER_OFF: begin
                if (en_i) begin
                    state_d = CLUSTER_CLK_ON;
                    cnt_d   = load_val;
                end
            end
            CLUSTER_CLK_ON: begin
                if (!en_i)                state_d = CLUSTER_OFF;
                else if (cnt_q == 8'd1)   state_d = CLUSTER_RUN;
                else                      cnt_d   = cnt_q - 8'd1;
            end
            CLUSTER_RUN: begin
                if (!en_i) state_d = CLUSTER_ISOLATE;
            end
            // EN is deliberately ignored here so a started shutdown always drains.
            CLUSTER_ISOLATE: begin
                if (iso_ack_i) begin
                    state_d = CLUSTER_RST_WAIT;
                    cnt_d   = load_val;
                end
            end
            CLUSTER_RST_WAIT: begin
                if (cnt_q == 8'd1) state_d = CLUSTER_OFF;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = CLUSTER_OFF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q                      <= CLUSTER_OFF;
            cnt_q                        <= 8'd0;
            {clk_en_o, rst_o, iso_o}     <= seq_outputs(CLUSTER_OFF);
        end else begin
            state_q                      <= state_d;
            cnt_q                        <= cnt_d;
            {clk_en_o, rst_o, iso_o}     <= seq_outputs(state_d);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/chimera_cluster_ctrl.sv
// APB register block for per-cluster enable, boot address, status and sequencing delay.
// Instantiates one power sequencer per cluster.
module chimera_cluster_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters     = chimera_pkg::ExtClusters,
    parameter logic [31:0] BootAddrDefault = chimera_pkg::SnitchBootROMRegionStart[31:0],
    parameter logic [7:0]  DelayDefault    = chimera_pkg::DelayDefault
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  apb_req_t                  apb_req_i,
    output apb_resp_t                 apb_rsp_o,
    output logic [NumClusters-1:0]    clk_en_o,
    output logic [NumClusters-1:0]    rst_o,
    output logic [NumClusters-1:0]    iso_o,
    input  logic [NumClusters-1:0]    iso_ack_i,
    output logic [NumClusters*32-1:0] boot_addr_o
);

    logic [NumClusters-1:0] en_q;
    logic [31:0]            boot_q [NumClusters];
    logic [7:0]             delay_q;
    logic [2:0]             state  [NumClusters];

    logic        access, wr_ok, err, idx_ok;
    logic        sel_ctrl, sel_boot, sel_status, sel_delay;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [4:0]  bank;
    logic [31:0] rdata;
    logic        unused_req;

    assign unused_req = ^{apb_req_i.pprot, apb_req_i.paddr[31:12]};

    assign access = apb_req_i.psel & apb_req_i.penable;
    assign addr   = apb_req_i.paddr[11:0];
    assign idx    = addr[6:2];
    assign bank   = addr[11:7];
    assign idx_ok = 32'(idx) < NumClusters;

    always_comb begin
        sel_ctrl   = (bank == CtrlOffset[11:7])     && idx_ok;
        sel_boot   = (bank == BootAddrOffset[11:7]) && idx_ok;
        sel_status = (bank == StatusOffset[11:7])   && idx_ok;
        sel_delay  = (addr[11:2] == DelayOffset[11:2]);
        err        = (addr[1:0] != 2'b00)
                   || !(sel_ctrl || sel_boot || sel_status || sel_delay)
                   || (sel_status && apb_req_i.pwrite);
    end

    assign wr_ok = access & apb_req_i.pwrite & ~err;

    always_comb begin
        rdata = 32'd0;
        for (int i = 0; i < NumClusters; i++) begin
            if (idx == 5'(i)) begin
                if (sel_ctrl)   rdata = {31'd0, en_q[i]};
                if (sel_boot)   rdata = boot_q[i];
                if (sel_status) rdata = {29'd0, state[i]};
            end
        end
        if (sel_delay) rdata = {24'd0, delay_q};
    end

    always_comb begin
        apb_rsp_o.pready  = access;
        apb_rsp_o.pslverr = access & err;
        apb_rsp_o.prdata  = (access && !err) ? rdata : 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= '0;
            delay_q <= DelayDefault;
            for (int i = 0; i < NumClusters; i++) boot_q[i] <= BootAddrDefault;
        end else if (wr_ok) begin
            if (sel_delay && apb_req_i.pstrb[0]) delay_q <= apb_req_i.pwdata[7:0];
            for (int i = 0; i < NumClusters; i++) begin
                if (idx == 5'(i)) begin
                    if (sel_ctrl && apb_req_i.pstrb[0]) en_q[i] <= apb_req_i.pwdata[0];
                    if (sel_boot) begin
                        for (int b = 0; b < 4; b++) begin
                            if (apb_req_i.pstrb[b]) boot_q[i][8*b +: 8] <= apb_req_i.pwdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NumClusters; g++) begin : gen_seq
        chimera_cluster_seq u_seq (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_q[g]),
            .delay_i   (delay_q),
            .iso_ack_i (iso_ack_i[g]),
            .clk_en_o  (clk_en_o[g]),
            .rst_o     (rst_o[g]),
            .iso_o     (iso_o[g]),
            .state_o   (state[g])
        );
        assign boot_addr_o[32*g +: 32] = boot_q[g];
    end

endmodule
